// File: rtl/score_display.sv
// score_display: scans left score, two dashes and right score onto a 4-digit common-anode 7-segment display, blinking the winner's digit.
module score_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Lftscore,
  input  logic [3:0] Rgtscore,
  input  logic       Lftwin,
  input  logic       Rgtwin,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [9:0] sync1, sync2, snap;
  logic [SW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic [1:0] dig;
  logic phase, wrap, bwrap;
  logic [6:0] lft_glyph, rgt_glyph, nxt_seg;
  logic [3:0] nxt_an;
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h06;
    endcase
  endfunction
  assign wrap  = cnt == SW'(SCAN_DIV - 1);
  assign bwrap = bcnt == BW'(BLINK_DIV - 1);
  // snap layout: {Lftwin, Rgtwin, Lftscore, Rgtscore}
  always_comb begin
    lft_glyph = (snap[9] && !phase) ? 7'h7F : glyph(snap[7:4]);
    rgt_glyph = (snap[8] && !phase) ? 7'h7F : glyph(snap[3:0]);
    nxt_seg   = (cnt == '0) ? 7'h7F : (dig == 2'd3) ? lft_glyph : (dig == 2'd0) ? rgt_glyph : 7'h3F;
    nxt_an    = (cnt == '0) ? 4'hF : ~(4'b0001 << dig);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      snap  <= '0;
      cnt   <= '0;
      dig   <= 2'd3;
      bcnt  <= '0;
      phase <= 1'b1;
      an    <= 4'hF;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end else begin
      sync1 <= {Lftwin, Rgtwin, Lftscore, Rgtscore};
      sync2 <= sync1;
      if (cnt == '0 && dig == 2'd3) snap <= sync2;
      cnt   <= wrap ? '0 : cnt + SW'(1);
      if (wrap) dig <= dig - 2'd1;
      bcnt  <= bwrap ? '0 : bcnt + BW'(1);
      if (bwrap) phase <= ~phase;
      an    <= nxt_an;
      seg   <= nxt_seg;
      dp    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: random and directed scoreboard scenarios checked cycle by cycle against an edge-count model.
module tb_score_display;
  localparam int S = 4;
  localparam int B = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] lft = 4'd3, rgt = 4'd2;
  logic lw = 1'b0, rw = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  int n_checks = 0;
  int n_fail = 0;
  int k = 0;
  logic [9:0] hist [0:8191];
  logic [6:0] digits [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  score_display #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk(clk), .reset(reset), .Lftscore(lft), .Rgtscore(rgt),
    .Lftwin(lw), .Rgtwin(rw), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got={an,seg,dp}=%h expected=%h", tag, k, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    return (v > 4'd9) ? 7'h06 : digits[v];
  endfunction

  // Output seen after the k-th edge since reset release, from the state reached after k-1 edges.
  function automatic logic [11:0] expect_out(input int kk);
    int c, d, j;
    logic [9:0] sn;
    logic ph;
    logic [6:0] sg;
    c = (kk - 1) % S;
    if (c == 0) return 12'hFFF;
    d = 3 - ((kk - 1) / S) % 4;
    j = ((kk - 2) / (4 * S)) * 4 * S + 1;
    sn = (j >= 3) ? hist[j-2] : 10'd0;
    ph = ((((kk - 1) / B) % 2) == 0);
    if (d == 3) sg = (sn[9] && !ph) ? 7'h7F : glyph(sn[7:4]);
    else if (d == 0) sg = (sn[8] && !ph) ? 7'h7F : glyph(sn[3:0]);
    else sg = 7'h3F;
    return {~(4'b0001 << d), sg, 1'b1};
  endfunction

  task automatic step(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      hist[k] = {lw, rw, lft, rgt};
      @(negedge clk);
      check(tag, {an, seg, dp}, expect_out(k));
    end
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #1 check({tag, "_async"}, {an, seg, dp}, 12'hFFF);
    @(negedge clk);
    check({tag, "_held"}, {an, seg, dp}, 12'hFFF);
    reset = 1'b1;
    k = 0;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_hold", {an, seg, dp}, 12'hFFF);
    end
    reset = 1'b1;
    step("basic_scan", 64);
    lft = 4'd1;
    step("pre_snap", 40);
    for (int i = 0; i < 16 && (k - 1) % 16 != 9; i++) step("seek_d1", 1);
    lft = 4'd4;
    step("snap_timing", 40);
    rgt = 4'd12;
    step("out_of_range", 32);
    lft = 4'd5;
    lw = 1'b1;
    step("left_blink", 80);
    rw = 1'b1;
    step("both_blink", 80);
    lw = 1'b0;
    rw = 1'b0;
    step("win_clear", 40);
    for (int i = 0; i < 16 && (k - 1) % 16 != 14; i++) step("seek_d0", 1);
    pulse_reset("mid_reset");
    step("after_reset", 40);
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(5) == 0) begin
        lft = 4'($urandom_range(15));
        rgt = 4'($urandom_range(15));
        lw  = ($urandom_range(2) == 0);
        rw  = ($urandom_range(2) == 0);
      end
      if (i == 450) pulse_reset("rand_reset");
      step("random", 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
